// File: rtl/podium_sequencer.sv
// ----------------------------------------------------------------------------
// podium_sequencer
//   Walks through all 24 orderings of the finishers {0,1,2,3} in lexicographic
//   order and presents one podium word per valid/ready handshake. Each word
//   carries the four finishers, the inverse map (position of each value) and
//   the lexicographic rank. Intended to feed the N0..N3 inputs of the
//   podium_permutations checker.
//
//   Parameters
//     WRAP        1: after rank 23 restart at FIRST_RANK; 0: finish and go idle
//     FIRST_RANK  rank of the first word after start (legal 0..23)
//
//   Ports
//     clk_i        clock, rising edge
//     rst_i        asynchronous active-high reset
//     start_i      begin a sequence (only looked at while idle)
//     stop_i       abort the sequence, back to idle next cycle, no done
//     out_ready_i  consumer accepts the current word
//     out_valid_o  word outputs are valid
//     n0_o..n3_o   finisher in podium position 0..3
//     imap_o       imap_o[2v+1:2v] = position holding value v
//     rank_o       lexicographic index of the current word
//     last_o       valid word with rank 23
//     done_o       one-cycle pulse at the end of a pass
//     busy_o       sequencer is not idle
// ----------------------------------------------------------------------------
module podium_sequencer #(
   parameter bit          WRAP       = 1'b0,
   parameter int unsigned FIRST_RANK = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       out_ready_i,
   output logic       out_valid_o,
   output logic [1:0] n0_o,
   output logic [1:0] n1_o,
   output logic [1:0] n2_o,
   output logic [1:0] n3_o,
   output logic [7:0] imap_o,
   output logic [4:0] rank_o,
   output logic       last_o,
   output logic       done_o,
   output logic       busy_o
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

   // Mixed-radix digits of FIRST_RANK (rank = 6*d0 + 2*d1 + d2). A value
   // above 23 is outside the legal range and yields an undefined sequence.
   localparam logic [1:0] FD0 = 2'(FIRST_RANK / 6);
   localparam logic [1:0] FD1 = 2'((FIRST_RANK % 6) / 2);
   localparam logic       FD2 = 1'(FIRST_RANK % 2);

   state_e     state_q, state_d;
   logic [1:0] d0_q, d0_d, d1_q, d1_d;
   logic       d2_q, d2_d;
   logic       done_q, done_d;
   logic       upd_d;
   logic [7:0] word_q, imap_q;
   logic [4:0] rank_q, rank_d;
   logic [15:0] dec_d;
   logic       accept, at_end;

   // k-th smallest value not yet marked in 'used'
   function automatic logic [1:0] pick(input logic [3:0] used, input logic [1:0] k);
      logic [2:0] cnt;
      pick = 2'd0;
      cnt  = 3'd0;
      for (int v = 0; v < 4; v++) begin
         if (!used[v]) begin
            if (cnt == {1'b0, k}) pick = v[1:0];
            cnt = cnt + 3'd1;
         end
      end
   endfunction

   // digits -> {N0,N1,N2,N3, IMAP}
   function automatic logic [15:0] decode(input logic [1:0] a, input logic [1:0] b,
                                          input logic c);
      logic [3:0] used;
      logic [1:0] v [4];
      logic [7:0] im;
      used = 4'b0;
      v[0] = pick(used, a);          used[v[0]] = 1'b1;
      v[1] = pick(used, b);          used[v[1]] = 1'b1;
      v[2] = pick(used, {1'b0, c});  used[v[2]] = 1'b1;
      v[3] = pick(used, 2'd0);
      im = 8'h00;
      for (int p = 0; p < 4; p++) im[{v[p], 1'b0} +: 2] = p[1:0];
      decode = {v[0], v[1], v[2], v[3], im};
   endfunction

   assign accept = (state_q == EMIT) && out_ready_i;
   assign at_end = (rank_q == 5'd23);

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i && !stop_i) state_d = EMIT;
         EMIT: begin
            if (stop_i)                          state_d = IDLE;
            else if (accept && at_end && !WRAP)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // datapath next values: counter load/advance and done pulse
   always_comb begin
      d0_d   = d0_q;
      d1_d   = d1_q;
      d2_d   = d2_q;
      done_d = 1'b0;
      upd_d  = 1'b0;
      case (state_q)
         IDLE: if (start_i && !stop_i) begin
            d0_d = FD0; d1_d = FD1; d2_d = FD2; upd_d = 1'b1;
         end
         EMIT: if (!stop_i && accept) begin
            upd_d = 1'b1;
            if (!at_end) begin
               // d2 radix 2, d1 radix 3, d0 radix 4; rank 23 never advances
               if (!d2_q) d2_d = 1'b1;
               else begin
                  d2_d = 1'b0;
                  if (d1_q != 2'd2) d1_d = d1_q + 2'd1;
                  else begin
                     d1_d = 2'd0;
                     d0_d = d0_q + 2'd1;
                  end
               end
            end else begin
               done_d = 1'b1;
               if (WRAP) begin
                  d0_d = FD0; d1_d = FD1; d2_d = FD2;
               end else begin
                  upd_d = 1'b0;  // last word stays on the outputs
               end
            end
         end
         default: ;
      endcase
   end

   assign rank_d = ({3'b0, d0_d} * 5'd6) + {2'b0, d1_d, 1'b0} + {4'b0, d2_d};
   assign dec_d  = decode(d0_d, d1_d, d2_d);

   // word registers: N/IMAP/RANK move together
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         d0_q   <= 2'd0;
         d1_q   <= 2'd0;
         d2_q   <= 1'b0;
         done_q <= 1'b0;
         word_q <= 8'h00;
         imap_q <= 8'h00;
         rank_q <= 5'd0;
      end else begin
         done_q <= done_d;
         if (upd_d) begin
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            word_q <= dec_d[15:8];
            imap_q <= dec_d[7:0];
            rank_q <= rank_d;
         end
      end
   end

   assign out_valid_o = (state_q == EMIT);
   assign busy_o      = (state_q != IDLE);
   assign last_o      = out_valid_o && at_end;
   assign done_o      = done_q;
   assign n0_o        = word_q[7:6];
   assign n1_o        = word_q[5:4];
   assign n2_o        = word_q[3:2];
   assign n3_o        = word_q[1:0];
   assign imap_o      = imap_q;
   assign rank_o      = rank_q;

endmodule

// File: tb/tb_podium_sequencer.sv
module tb_podium_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, stop = 1'b0, ready = 1'b0;

   // instance 0: WRAP=0, FIRST_RANK=0 ; instance 1: WRAP=1, FIRST_RANK=5
   logic       ov [2], lst [2], dn [2], bsy [2];
   logic [1:0] n0 [2], n1 [2], n2 [2], n3 [2];
   logic [7:0] im [2];
   logic [4:0] rk [2];

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   podium_sequencer #(.WRAP(1'b0), .FIRST_RANK(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .out_ready_i(ready),
      .out_valid_o(ov[0]), .n0_o(n0[0]), .n1_o(n1[0]), .n2_o(n2[0]), .n3_o(n3[0]),
      .imap_o(im[0]), .rank_o(rk[0]), .last_o(lst[0]), .done_o(dn[0]), .busy_o(bsy[0]));

   podium_sequencer #(.WRAP(1'b1), .FIRST_RANK(5)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .out_ready_i(ready),
      .out_valid_o(ov[1]), .n0_o(n0[1]), .n1_o(n1[1]), .n2_o(n2[1]), .n3_o(n3[1]),
      .imap_o(im[1]), .rank_o(rk[1]), .last_o(lst[1]), .done_o(dn[1]), .busy_o(bsy[1]));

   // ---------------- model ----------------
   // all permutations, enumerated directly in lexicographic order
   logic [7:0] perm [24];
   initial begin
      int idx;
      idx = 0;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
               for (int d = 0; d < 4; d++)
                  if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                     perm[idx] = {a[1:0], b[1:0], c[1:0], d[1:0]};
                     idx++;
                  end
   end

   int m_fr [2] = '{0, 5};
   bit m_wr [2] = '{1'b0, 1'b1};
   int m_rank [2];
   bit m_act [2], m_done [2], m_fresh [2];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i] <= 1'b0; m_rank[i] <= 0; m_done[i] <= 1'b0; m_fresh[i] <= 1'b1;
         end else begin
            m_done[i] <= 1'b0;
            if (!m_act[i]) begin
               if (start && !stop) begin
                  m_act[i] <= 1'b1; m_rank[i] <= m_fr[i]; m_fresh[i] <= 1'b0;
               end
            end else if (stop) begin
               m_act[i] <= 1'b0;
            end else if (ready) begin
               if (m_rank[i] < 23) m_rank[i] <= m_rank[i] + 1;
               else begin
                  m_done[i] <= 1'b1;
                  if (m_wr[i]) m_rank[i] <= m_fr[i];
                  else         m_act[i]  <= 1'b0;
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
      end
   endtask

   task automatic check_reset();
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", i, 32'(ov[i]), 0);
         check("rst_busy",  i, 32'(bsy[i]), 0);
         check("rst_done",  i, 32'(dn[i]), 0);
         check("rst_rank",  i, 32'(rk[i]), 0);
         check("rst_word",  i, 32'({n0[i], n1[i], n2[i], n3[i]}), 0);
         check("rst_imap",  i, 32'(im[i]), 0);
      end
   endtask

   // ---------------- compare, every cycle ----------------
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            logic [7:0] ew, ei, w;
            logic [1:0] v;
            ew = m_fresh[i] ? 8'h00 : perm[m_rank[i]];
            ei = 8'h00;
            if (!m_fresh[i])
               for (int p = 0; p < 4; p++) begin
                  v = ew[7-2*p -: 2];
                  ei[2*v +: 2] = p[1:0];
               end
            w = {n0[i], n1[i], n2[i], n3[i]};
            check("valid", i, 32'(ov[i]),  32'(m_act[i]));
            check("busy",  i, 32'(bsy[i]), 32'(m_act[i]));
            check("done",  i, 32'(dn[i]),  32'(m_done[i]));
            check("rank",  i, 32'(rk[i]),  32'(m_fresh[i] ? 0 : m_rank[i]));
            check("last",  i, 32'(lst[i]), 32'(m_act[i] && m_rank[i] == 23));
            check("word",  i, 32'(w), 32'(ew));
            check("imap",  i, 32'(im[i]), 32'(ei));
            // literal anchors for the model
            if (ov[i] && rk[i] == 5'd0)  begin check("r0_word", i, 32'(w), 32'h1B); check("r0_imap", i, 32'(im[i]), 32'hE4); end
            if (ov[i] && rk[i] == 5'd1)  begin check("r1_word", i, 32'(w), 32'h1E); check("r1_imap", i, 32'(im[i]), 32'hB4); end
            if (ov[i] && rk[i] == 5'd6)  begin check("r6_word", i, 32'(w), 32'h4B); check("r6_imap", i, 32'(im[i]), 32'hE1); end
            if (ov[i] && rk[i] == 5'd23) begin check("r23_word", i, 32'(w), 32'hE4); check("r23_imap", i, 32'(im[i]), 32'h1B); end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(1); stop = 1'b0;
   endtask

   task automatic wait_rank0(input int r, input string nm);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (ov[0] && rk[0] == 5'(r)) found = 1'b1;
      end
      #1;
      check(nm, 0, 32'(found), 1);
   endtask

   initial begin
      #1;
      check_reset();
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // full pass / wrap from 5
      ready = 1'b1;
      pulse_start();
      cyc(30);
      pulse_stop();
      cyc(2);

      // START and STOP together while idle: nothing happens
      start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
      cyc(2);

      // backpressure 1,0,0,...
      pulse_start();
      for (int k = 0; k < 80; k++) begin
         ready = (k % 3 == 0);
         cyc(1);
      end
      ready = 1'b1;
      pulse_stop();
      cyc(2);

      // stop together with an accept on rank 10, then restart
      pulse_start();
      wait_rank0(10, "wait_r10");
      stop = 1'b1; cyc(1); stop = 1'b0;
      cyc(2);
      pulse_start();
      cyc(4);

      // reset in the middle of a sequence, start while busy ignored
      pulse_stop();
      pulse_start();
      wait_rank0(14, "wait_r14");
      start = 1'b1; cyc(1); start = 1'b0;
      rst = 1'b1;
      #1;
      check_reset();
      cyc(2);
      rst = 1'b0;
      cyc(3);
      pulse_start();
      cyc(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
